// File: rtl/apb_fifo_slave.sv
// APB slave wrapping a DEPTH x DATA_W synchronous FIFO behind STATUS/TXDATA/RXDATA/CTRL registers.
// Optional interrupt output is enabled by defining APB_FIFO_IRQ_EN.
module apb_fifo_slave #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
`ifdef APB_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              overflow, underflow, irq_en;
  logic              empty, full;
  logic              access, commit;
  logic [1:0]        sel;
  logic              wr_tx, rd_rx, wr_ctrl, flush, push_ok;
  logic [31:0]       status_word, rd_word;
  logic              unused_ok;

  // Handshake: a transfer is one SETUP cycle then ACCESS; PREADY is low for the
  // first ACCESS cycle and high for the second, and the edge that sees
  // PSEL&PENABLE&PREADY is the one and only commit edge of the transfer.
  assign access = PSEL & PENABLE;
  assign commit = access & PREADY;
  assign sel    = PADDR[3:2];

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign wr_tx   = commit &  PWRITE & (sel == 2'd1);
  assign rd_rx   = commit & !PWRITE & (sel == 2'd2);
  assign wr_ctrl = commit &  PWRITE & (sel == 2'd3);
  assign flush   = wr_ctrl & PWDATA[0];
  assign push_ok = wr_tx & !full;

  assign unused_ok = &{1'b0, PADDR, PWDATA};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY <= 1'b0;
    end else begin
      PREADY <= access & !PREADY;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_tx) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + (AW+1)'(1);
        end
      end
      if (rd_rx) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - (AW+1)'(1);
        end
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= PWDATA[DATA_W-1:0];
    end
  end

`ifdef APB_FIFO_IRQ_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= PWDATA[1];
      end
      irq <= irq_en & !empty;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    status_word            = '0;
    status_word[0]         = empty;
    status_word[1]         = full;
    status_word[2]         = overflow;
    status_word[3]         = underflow;
    status_word[8 +: AW+1] = count;
  end

  // The pre-pop head is presented for both ACCESS cycles; pointers move only at commit.
  always_comb begin
    rd_word = '0;
    PRDATA  = '0;
    if (!empty) begin
      rd_word[DATA_W-1:0] = mem[rd_ptr];
    end
    if (access && !PWRITE) begin
      case (sel)
        2'd0:    PRDATA = status_word;
        2'd2:    PRDATA = rd_word;
        2'd3:    PRDATA = {30'd0, irq_en, 1'b0};
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench for apb_fifo_slave: register map, FIFO ordering, full/empty flags,
// flush, wrap-around, reset during a transfer and (when built with it) the interrupt.
module tb_apb_fifo_slave;

  localparam logic [31:0] BASE    = 32'h1000_1000;
  localparam logic [31:0] A_STAT  = BASE + 32'h0;
  localparam logic [31:0] A_TX    = BASE + 32'h4;
  localparam logic [31:0] A_RX    = BASE + 32'h8;
  localparam logic [31:0] A_CTRL  = BASE + 32'hC;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef APB_FIFO_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  apb_fifo_slave #(.DEPTH(8), .DATA_W(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
`ifdef APB_FIFO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [31:0] rdata_first,
                          output logic ready_first);
    int n;
    @(negedge PCLK);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    ready_first = PREADY;
    rdata_first = PRDATA;
    n = 0;
    while (!PREADY && n < 8) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    if (!PREADY) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout addr=%h got PREADY=%b want 1", addr, PREADY);
    end
    rdata = PRDATA;
    @(negedge PCLK);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d, d0;
    logic r0;
    apb_xfer(1'b1, addr, wdata, d, d0, r0);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata);
    logic [31:0] d0;
    logic r0;
    apb_xfer(1'b0, addr, 32'h0, rdata, d0, r0);
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, d0;
    logic r0;
    PRESET = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", PREADY); end
    checks++;
    if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", PRDATA); end
    PRESET = 1'b0;
    apb_xfer(1'b0, A_STAT, 32'h0, d, d0, r0);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got %h want 00000001", d); end
    checks++;
    if (r0 !== 1'b0) begin errors++; $display("FAIL first_access_pready got %b want 0", r0); end
    checks++;
    if (d0 !== 32'h0000_0001) begin errors++; $display("FAIL first_access_prdata got %h want 00000001", d0); end
  endtask

  task automatic test_fifo_basic();
    logic [31:0] d, d0;
    logic r0;
    apb_write(A_TX, 32'h0000_00A5);
    apb_write(A_TX, 32'h0000_003C);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0200) begin errors++; $display("FAIL basic_status2 got %h want 00000200", d); end
    apb_xfer(1'b0, A_RX, 32'h0, d, d0, r0);
    checks++;
    if (d !== 32'h0000_00A5) begin errors++; $display("FAIL basic_pop1 got %h want 000000a5", d); end
    checks++;
    if (d0 !== 32'h0000_00A5) begin errors++; $display("FAIL basic_pop1_hold got %h want 000000a5", d0); end
    apb_read(A_RX, d);
    checks++;
    if (d !== 32'h0000_003C) begin errors++; $display("FAIL basic_pop2 got %h want 0000003c", d); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL basic_status0 got %h want 00000001", d); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) apb_write(A_TX, 32'(i));
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0802) begin errors++; $display("FAIL full_status got %h want 00000802", d); end
    apb_write(A_TX, 32'h0000_00FF);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0806) begin errors++; $display("FAIL overflow_status got %h want 00000806", d); end
    for (int i = 0; i < 8; i++) begin
      apb_read(A_RX, d);
      checks++;
      if (d !== 32'(i)) begin errors++; $display("FAIL full_pop%0d got %h want %h", i, d, 32'(i)); end
    end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0005) begin errors++; $display("FAIL drained_status got %h want 00000005", d); end
    apb_write(A_CTRL, 32'h1);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_ovf_status got %h want 00000001", d); end
  endtask

  task automatic test_underflow_flush();
    logic [31:0] d;
    do_reset();
    apb_read(A_RX, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_pop got %h want 0", d); end
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0009) begin errors++; $display("FAIL underflow_status got %h want 00000009", d); end
    apb_write(A_CTRL, 32'h1);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_status got %h want 00000001", d); end
    apb_read(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_flush_reads0 got %h want 0", d); end
  endtask

  task automatic test_decode_misc();
    logic [31:0] d;
    apb_write(32'hFFFF_FFF6, 32'hDEAD_BE12);
    apb_write(A_RX, 32'h0000_0099);
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0100) begin errors++; $display("FAIL alias_push_status got %h want 00000100", d); end
    apb_read(A_TX, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got %h want 0", d); end
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_TX; PWDATA = 32'h77;
    repeat (3) @(negedge PCLK);
    PSEL = 1'b0; PWRITE = 1'b0;
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0100) begin errors++; $display("FAIL setup_only_status got %h want 00000100", d); end
    apb_read(A_RX, d);
    checks++;
    if (d !== 32'h0000_0012) begin errors++; $display("FAIL alias_pop got %h want 00000012", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      apb_write(A_TX, 32'(i * 3));
      apb_read(A_STAT, d);
      checks++;
      if (d !== 32'h0000_0100) begin errors++; $display("FAIL wrap_status%0d got %h want 00000100", i, d); end
      apb_read(A_RX, d);
      checks++;
      if (d !== 32'(i * 3)) begin errors++; $display("FAIL wrap_pop%0d got %h want %h", i, d, 32'(i * 3)); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_TX; PWDATA = 32'h55;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    #1;
    checks++;
    if (PREADY !== 1'b1) begin errors++; $display("FAIL mid_pready_before got %b want 1", PREADY); end
    PRESET = 1'b1;
    #1;
    checks++;
    if (PREADY !== 1'b0) begin errors++; $display("FAIL mid_pready_reset got %b want 0", PREADY); end
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL mid_reset_status got %h want 00000001", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    apb_write(A_CTRL, 32'h2);
    apb_read(A_CTRL, d);
`ifdef APB_FIFO_IRQ_EN
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL ctrl_irq_en got %h want 2", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
    apb_write(A_TX, 32'h11);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_at_commit got %b want 0", irq); end
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    apb_read(A_RX, d);
    checks++;
    if (d !== 32'h11) begin errors++; $display("FAIL irq_pop got %h want 11", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
`else
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_no_irq got %h want 0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_full_overflow();
    test_underflow_flush();
    test_decode_misc();
    test_wrap();
    test_reset_mid_transfer();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
